// File: rtl/ballot_controller.sv
// Per-voter ballot sequencer: arms one ballot per officer request, forwards a single valid
// vote as a one-cycle one-hot grant, and rejects spoilt, late or out-of-turn presses.
module ballot_controller #(
    parameter int unsigned NUM_CAND       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CONFIRM_CYCLES = 25000000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                open_poll,
    input  logic                close_poll,
    input  logic                issue_ballot,
    input  logic [NUM_CAND-1:0] vote_req,
    output logic [NUM_CAND-1:0] vote_grant,
    output logic [NUM_CAND-1:0] last_choice,
    output logic                poll_open,
    output logic                ballot_ready,
    output logic                spoilt,
    output logic                timeout,
    output logic                ignored,
    output logic [CNT_W-1:0]    ballots_issued,
    output logic [CNT_W-1:0]    votes_granted
);

    localparam int unsigned TMAX = (TIMEOUT_CYCLES > CONFIRM_CYCLES) ? TIMEOUT_CYCLES
                                                                      : CONFIRM_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {StClosed, StIdle, StArmed, StConfirm} state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                close_pending_q, close_pending_d;
    logic [NUM_CAND-1:0] grant_q, grant_d;
    logic [NUM_CAND-1:0] last_q, last_d;
    logic                poll_open_q, poll_open_d;
    logic                ready_q, ready_d;
    logic                spoilt_q, spoilt_d;
    logic                timeout_q, timeout_d;
    logic                ignored_q, ignored_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    granted_q, granted_d;

    logic req_any;
    logic req_one;

    assign req_any = |vote_req;
    // Clearing the lowest set bit leaves zero only for a single-bit request.
    assign req_one = req_any && ((vote_req & (vote_req - NUM_CAND'(1))) == '0);

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        close_pending_d = close_pending_q;
        grant_d         = '0;
        last_d          = last_q;
        spoilt_d        = 1'b0;
        timeout_d       = 1'b0;
        ignored_d       = 1'b0;
        issued_d        = issued_q;
        granted_d       = granted_q;

        unique case (state_q)
            StClosed: begin
                ignored_d = req_any;
                if (open_poll) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                ignored_d = req_any;
                if (close_poll) begin
                    state_d = StClosed;
                end else if (issue_ballot) begin
                    state_d  = StArmed;
                    timer_d  = '0;
                    issued_d = (issued_q == '1) ? issued_q : issued_q + CNT_W'(1);
                end
            end
            StArmed: begin
                if (close_poll) begin
                    close_pending_d = 1'b1;
                end
                if (req_one) begin
                    grant_d   = vote_req;
                    last_d    = vote_req;
                    granted_d = (granted_q == '1) ? granted_q : granted_q + CNT_W'(1);
                    state_d   = StConfirm;
                    timer_d   = '0;
                end else if (req_any) begin
                    spoilt_d = 1'b1;
                    last_d   = '0;
                    state_d  = StConfirm;
                    timer_d  = '0;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    last_d    = '0;
                    state_d   = StConfirm;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StConfirm: begin
                ignored_d = req_any;
                if (timer_q == TW'(CONFIRM_CYCLES - 1)) begin
                    // A close arriving on the exit cycle still closes the poll.
                    state_d         = (close_pending_q || close_poll) ? StClosed : StIdle;
                    close_pending_d = 1'b0;
                    timer_d         = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (close_poll) begin
                        close_pending_d = 1'b1;
                    end
                end
            end
            default: state_d = StClosed;
        endcase

        poll_open_d = (state_d != StClosed);
        ready_d     = (state_d == StArmed);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StClosed;
            timer_q         <= '0;
            close_pending_q <= 1'b0;
            grant_q         <= '0;
            last_q          <= '0;
            poll_open_q     <= 1'b0;
            ready_q         <= 1'b0;
            spoilt_q        <= 1'b0;
            timeout_q       <= 1'b0;
            ignored_q       <= 1'b0;
            issued_q        <= '0;
            granted_q       <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            close_pending_q <= close_pending_d;
            grant_q         <= grant_d;
            last_q          <= last_d;
            poll_open_q     <= poll_open_d;
            ready_q         <= ready_d;
            spoilt_q        <= spoilt_d;
            timeout_q       <= timeout_d;
            ignored_q       <= ignored_d;
            issued_q        <= issued_d;
            granted_q       <= granted_d;
        end
    end

    assign vote_grant     = grant_q;
    assign last_choice    = last_q;
    assign poll_open      = poll_open_q;
    assign ballot_ready   = ready_q;
    assign spoilt         = spoilt_q;
    assign timeout        = timeout_q;
    assign ignored        = ignored_q;
    assign ballots_issued = issued_q;
    assign votes_granted  = granted_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Scoreboard bench for ballot_controller: a cycle-level poll model queues expected pulses
// and status; a monitor compares them against the DUT one cycle after each stimulus.
module tb_ballot_controller;

    localparam int unsigned NC  = 4;
    localparam int unsigned TO  = 20;
    localparam int unsigned CF  = 5;
    localparam int unsigned CW  = 2;
    localparam int          SAT = (1 << CW) - 1;

    localparam int PH_CLOSED  = 0;
    localparam int PH_IDLE    = 1;
    localparam int PH_ARMED   = 2;
    localparam int PH_CONFIRM = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          open_poll = 1'b0;
    logic          close_poll = 1'b0;
    logic          issue_ballot = 1'b0;
    logic [NC-1:0] vote_req = '0;
    logic [NC-1:0] vote_grant;
    logic [NC-1:0] last_choice;
    logic          poll_open;
    logic          ballot_ready;
    logic          spoilt;
    logic          timeout;
    logic          ignored;
    logic [CW-1:0] ballots_issued;
    logic [CW-1:0] votes_granted;

    always #5 clk = ~clk;

    ballot_controller #(
        .NUM_CAND       (NC),
        .TIMEOUT_CYCLES (TO),
        .CONFIRM_CYCLES (CF),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .open_poll      (open_poll),
        .close_poll     (close_poll),
        .issue_ballot   (issue_ballot),
        .vote_req       (vote_req),
        .vote_grant     (vote_grant),
        .last_choice    (last_choice),
        .poll_open      (poll_open),
        .ballot_ready   (ballot_ready),
        .spoilt         (spoilt),
        .timeout        (timeout),
        .ignored        (ignored),
        .ballots_issued (ballots_issued),
        .votes_granted  (votes_granted)
    );

    typedef struct {
        int          stamp;
        logic [NC-1:0] grant;
        logic        sp;
        logic        to;
        logic        ig;
    } ev_t;

    typedef struct {
        int          stamp;
        logic        po;
        logic        br;
        logic [NC-1:0] last;
        int          iss;
        int          gr;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference poll model: phase plus a countdown/age instead of a shared timer.
    int            m_phase;
    int            m_age;
    int            m_left;
    bit            m_pend;
    logic [NC-1:0] m_last;
    int            m_iss;
    int            m_gr;

    task automatic model_reset();
        m_phase = PH_CLOSED;
        m_age   = 0;
        m_left  = 0;
        m_pend  = 0;
        m_last  = '0;
        m_iss   = 0;
        m_gr    = 0;
    endtask

    task automatic model_step(input bit o, input bit c, input bit i, input logic [NC-1:0] r);
        ev_t e;
        st_t s;
        int  n;
        n       = $countones(r);
        e.stamp = cyc + 1;
        e.grant = '0;
        e.sp    = 1'b0;
        e.to    = 1'b0;
        e.ig    = 1'b0;
        case (m_phase)
            PH_CLOSED: begin
                e.ig = (n > 0);
                if (o) m_phase = PH_IDLE;
            end
            PH_IDLE: begin
                e.ig = (n > 0);
                if (c) m_phase = PH_CLOSED;
                else if (i) begin
                    m_phase = PH_ARMED;
                    m_age   = 0;
                    if (m_iss < SAT) m_iss++;
                end
            end
            PH_ARMED: begin
                if (c) m_pend = 1;
                if (n == 1) begin
                    e.grant = r;
                    m_last  = r;
                    if (m_gr < SAT) m_gr++;
                    m_phase = PH_CONFIRM;
                    m_left  = CF;
                end else if (n > 1) begin
                    e.sp    = 1'b1;
                    m_last  = '0;
                    m_phase = PH_CONFIRM;
                    m_left  = CF;
                end else if (m_age + 1 == TO) begin
                    e.to    = 1'b1;
                    m_last  = '0;
                    m_phase = PH_CONFIRM;
                    m_left  = CF;
                end else begin
                    m_age++;
                end
            end
            default: begin
                e.ig = (n > 0);
                m_left--;
                if (m_left == 0) begin
                    m_phase = (m_pend || c) ? PH_CLOSED : PH_IDLE;
                    m_pend  = 0;
                end else if (c) begin
                    m_pend = 1;
                end
            end
        endcase
        if (e.grant != '0 || e.sp || e.to || e.ig) ev_q.push_back(e);
        s.stamp = cyc + 1;
        s.po    = (m_phase != PH_CLOSED);
        s.br    = (m_phase == PH_ARMED);
        s.last  = m_last;
        s.iss   = m_iss;
        s.gr    = m_gr;
        st_q.push_back(s);
    endtask

    task automatic step(input bit o, input bit c, input bit i, input logic [NC-1:0] r);
        @(negedge clk);
        open_poll    = o;
        close_poll   = c;
        issue_ballot = i;
        vote_req     = r;
        model_step(o, c, i, r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        open_poll    = 1'b0;
        close_poll   = 1'b0;
        issue_ballot = 1'b0;
        vote_req     = '0;
        #1;
        check("reset_outputs",
              32'({vote_grant, last_choice, poll_open, ballot_ready, spoilt, timeout, ignored,
                   ballots_issued, votes_granted}), 32'd0);
        ev_q.delete();
        st_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        ev_t e;
        st_t s;
        if (rst) begin
            while (ev_q.size() > 0 && ev_q[0].stamp < cyc) begin
                e = ev_q.pop_front();
                check("event_missed", 32'(cyc), 32'(e.stamp));
            end
            e.stamp = -1;
            e.grant = '0;
            e.sp    = 1'b0;
            e.to    = 1'b0;
            e.ig    = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].stamp == cyc) e = ev_q.pop_front();
            if (vote_grant != '0 || spoilt || timeout || ignored || e.stamp >= 0)
                check("event{grant,spoilt,timeout,ignored}",
                      32'({vote_grant, spoilt, timeout, ignored}),
                      32'({e.grant, e.sp, e.to, e.ig}));
            if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
                s = st_q.pop_front();
                check("status{poll_open,ready,last}",
                      32'({poll_open, ballot_ready, last_choice}),
                      32'({s.po, s.br, s.last}));
                check("ballots_issued", 32'(ballots_issued), 32'(s.iss));
                check("votes_granted", 32'(votes_granted), 32'(s.gr));
            end
        end
    end

    logic [NC-1:0] r;

    initial begin
        model_reset();
        do_reset();

        // Single valid vote.
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, 4'b0100);
        idle(7);
        // Spoilt ballot.
        step(0, 0, 1, '0);
        step(0, 0, 0, 4'b0011);
        idle(7);
        // Timeout, then a request landing in the expiry cycle.
        step(0, 0, 1, '0);
        idle(TO + CF + 2);
        step(0, 0, 1, '0);
        idle(TO - 1);
        step(0, 0, 0, 4'b0010);
        idle(7);
        // Ignored presses in IDLE, CONFIRM and CLOSED; second press after acceptance.
        step(0, 0, 0, 4'b0001);
        step(0, 0, 1, '0);
        step(0, 0, 0, 4'b1000);
        step(0, 0, 0, 4'b0001);
        idle(6);
        step(0, 1, 0, '0);
        step(0, 0, 0, 4'b0001);
        // Close during ARMED takes effect after CONFIRM.
        step(1, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 1, 0, '0);
        step(0, 0, 0, 4'b1000);
        idle(7);
        // Close and issue together in IDLE.
        step(1, 0, 0, '0);
        step(0, 1, 1, '0);
        idle(2);

        // Counter saturation.
        do_reset();
        step(1, 0, 0, '0);
        for (int b = 0; b < 5; b++) begin
            step(0, 0, 1, '0);
            r = 4'b0001 << $urandom_range(0, NC - 1);
            step(0, 0, 0, r);
            idle(6);
        end
        @(negedge clk);
        check("sat_ballots_issued", 32'(ballots_issued), 32'(SAT));
        check("sat_votes_granted", 32'(votes_granted), 32'(SAT));
        // Reset mid-ballot.
        step(0, 0, 1, '0);
        idle(3);
        do_reset();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            r = ($urandom_range(0, 99) < 70) ? '0 : NC'($urandom_range(1, (1 << NC) - 1));
            step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 25, r);
        end
        idle(2);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(ev_q.size() + st_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
Per-voter ballot sequencer between the four button debouncers and the vote storer. A presiding-officer control opens and closes the poll and issues one ballot per voter. Each issued ballot admits exactly one candidate vote, forwarded to the vote storer as a one-cycle one-hot grant. The block rejects extra or simultaneous presses, times out abandoned ballots, and holds a confirmation window before the next ballot can be issued.

Parameters:
NUM_CAND, 4, number of candidate request/grant lines
TIMEOUT_CYCLES, 50000000, cycles a ballot stays armed before it is cancelled
CONFIRM_CYCLES, 25000000, cycles the confirmation state is held after a ballot ends
CNT_W, 8, width of the ballot and vote counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
open_poll  in  1  single-cycle pulse; opens the poll
close_poll  in  1  single-cycle pulse; closes the poll
issue_ballot  in  1  single-cycle pulse; officer arms one ballot
vote_req  in  NUM_CAND  single-cycle valid-vote pulses from the button controllers
vote_grant  out  NUM_CAND  one-hot, single-cycle; increments a candidate in the vote storer
last_choice  out  NUM_CAND  one-hot latched choice; zero for a spoilt or timed-out ballot
poll_open  out  1  high in IDLE, ARMED and CONFIRM
ballot_ready  out  1  high in ARMED; drives the voter "vote now" LED
spoilt  out  1  single-cycle pulse; more than one request bit seen in ARMED
timeout  out  1  single-cycle pulse; armed ballot expired
ignored  out  1  single-cycle pulse; any request seen outside ARMED
ballots_issued  out  CNT_W  count of ballots armed since reset
votes_granted  out  CNT_W  count of grants since reset

Behaviour:
- Reset (rst=0, async): state CLOSED, all outputs 0, counters 0, timers 0, close_pending 0.
- States: CLOSED, IDLE, ARMED, CONFIRM. State is registered; every output is registered.
- CLOSED:
  - open_poll -> IDLE.
  - issue_ballot is ignored.
  - Any vote_req bit -> ignored pulse.
- IDLE:
  - close_poll -> CLOSED.
  - Otherwise issue_ballot -> ARMED; ballots_issued +1; timer cleared.
  - close_poll and issue_ballot in the same cycle: close wins and no ballot is issued.
- ARMED:
  - Exactly one vote_req bit set in cycle N: vote_grant equals that bit in cycle N+1 for one cycle only. In the same edge, last_choice latches the bit, votes_granted +1, and the state goes to CONFIRM.
  - Two or more bits set: no grant, spoilt pulse at N+1, last_choice = 0, state -> CONFIRM.
  - No request: timer increments. When the timer reaches TIMEOUT_CYCLES-1 with no request, timeout pulse, last_choice = 0, state -> CONFIRM.
  - A request in the expiry cycle takes priority over the timeout.
  - issue_ballot is ignored; no re-arm and no count.
  - close_poll sets close_pending and does not abort the ballot.
- CONFIRM:
  - Held for exactly CONFIRM_CYCLES cycles, then exit.
  - Exit goes to CLOSED if close_pending is set (close_pending then clears), else to IDLE.
  - Requests -> ignored pulse; issue_ballot is ignored; close_poll sets close_pending.
- open_poll is a no-op outside CLOSED.
- Counters saturate at 2^CNT_W-1; no wrap.
- last_choice holds its value until the next ARMED -> CONFIRM transition.
- Reset mid-ballot: any pending grant is dropped, state -> CLOSED, counters cleared.
- vote_grant is never asserted outside the cycle after an ARMED single request. At most one bit is ever set.

Test Plan:
- Reset, open_poll, issue_ballot, vote_req=4'b0100 -> vote_grant=4'b0100 one cycle later for one cycle; last_choice=4'b0100; ballots_issued=1; votes_granted=1; ballot_ready falls.
- Armed ballot, vote_req=4'b0011 -> vote_grant stays 0; spoilt=1 for one cycle; last_choice=0; votes_granted unchanged; state CONFIRM.
- TIMEOUT_CYCLES=20, CONFIRM_CYCLES=5; arm, no press -> timeout pulse 20 cycles after arming; ballot_ready low, then poll_open with ballot_ready=0 after 5 more cycles (IDLE). Also request in the expiry cycle -> grant issued, no timeout pulse.
- vote_req=4'b0001 in IDLE, CLOSED and CONFIRM -> ignored pulse each time; no grant; counters unchanged. A second press while armed after the first is accepted -> ignored, exactly one grant.
- close_poll during ARMED, then vote_req=4'b1000 -> grant 4'b1000; after CONFIRM, state CLOSED, poll_open=0. Separately, close_poll and issue_ballot together in IDLE -> CLOSED, ballots_issued unchanged.
- CNT_W=2; issue 5 ballots with valid votes -> ballots_issued=3, votes_granted=3 (saturated). Reset asserted mid-ARMED -> all outputs 0 immediately (async), state CLOSED.
